dev_bridge_ic: RTL

- System bridge and interrupt controller between the P7 CPU memory stage and its memory-mapped devices: two timer/counters (TC0, TC1) plus one external interrupt line.
- Decodes CPU word addresses and generates per-device write strobes.
- Muxes device read data back to the CPU.
- Latches, masks and prioritises device interrupts, and presents a registered 6-bit HWInt vector to CP0.

---
 rtl/dev_bridge_ic_pkg.sv | 24 ++
 rtl/dev_bridge_ic_irq_edge_latch.sv | 31 +++
 rtl/dev_bridge_ic.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dev_bridge_ic_pkg.sv
// Shared constants for the P7 device bridge and interrupt controller.
// Window bases, controller register offsets and interrupt source indices.
package dev_bridge_ic_pkg;

   localparam logic [31:0] TC0_BASE_DEF = 32'h0000_7F00;
   localparam logic [31:0] TC1_BASE_DEF = 32'h0000_7F10;
   localparam logic [31:0] IC_BASE_DEF  = 32'h0000_7F20;

   localparam int NSRC = 3;

   localparam logic [1:0] IC_IMASK = 2'd0;
   localparam logic [1:0] IC_IPEND = 2'd1;
   localparam logic [1:0] IC_IID   = 2'd2;

   localparam int SRC_TC0 = 0;
   localparam int SRC_TC1 = 1;
   localparam int SRC_EXT = 2;

   // A window holds three words; word offset 3 is deliberately unmapped.
   function automatic logic win_hit(input logic [29:0] waddr, input logic [31:0] base);
      return (waddr[29:2] == base[31:4]) && (waddr[1:0] != 2'd3);
   endfunction

endpackage

// File: rtl/dev_bridge_ic_irq_edge_latch.sv
// Rising-edge detector feeding a sticky pending flop; a new rise beats a clear.
// Latency: rise in cycle N shows on pend in cycle N+1; no backpressure.
module irq_edge_latch
   import dev_bridge_ic_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic src,
   input  logic clr,
   output logic pend
);

   logic prev;
   logic rise;

   assign rise = src & ~prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= 1'b0;
         pend <= 1'b0;
      end else begin
         prev <= src;
         if (rise)
            pend <= 1'b1;
         else if (clr)
            pend <= 1'b0;
      end
   end

endmodule

// File: rtl/dev_bridge_ic.sv
// Bridge/interrupt controller for TC0, TC1 and ext IRQ; decode is combinational, hw_int registered.
// No backpressure. Optional store trace under BRIDGE_TRACE_EN.
module dev_bridge_ic
   import dev_bridge_ic_pkg::*;
#(
   parameter logic [31:0] TC0_BASE = TC0_BASE_DEF,
   parameter logic [31:0] TC1_BASE = TC1_BASE_DEF,
   parameter logic [31:0] IC_BASE  = IC_BASE_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [31:0] cpu_wdata,
   input  logic [31:0] cpu_pc,
   output logic [31:0] cpu_rdata,
   output logic        cpu_hit,
   output logic [1:0]  dev_addr,
   output logic [31:0] dev_wdata,
   output logic        tc0_we,
   output logic        tc1_we,
   input  logic [31:0] tc0_rdata,
   input  logic [31:0] tc1_rdata,
   input  logic        tc0_irq,
   input  logic        tc1_irq,
   input  logic        ext_irq,
   output logic [5:0]  hw_int,
   input  logic        int_ack
);

   logic            hit_tc0, hit_tc1, hit_ic;
   logic            sync_1, sync_ext;
   logic [NSRC-1:0] src, clr, ipend, imask, active;
   logic [1:0]      iid;

   assign hit_tc0   = win_hit(cpu_addr, TC0_BASE);
   assign hit_tc1   = win_hit(cpu_addr, TC1_BASE);
   assign hit_ic    = win_hit(cpu_addr, IC_BASE);
   assign cpu_hit   = hit_tc0 | hit_tc1 | hit_ic;
   assign dev_addr  = cpu_addr[1:0];
   assign dev_wdata = cpu_wdata;
   assign tc0_we    = cpu_we & hit_tc0;
   assign tc1_we    = cpu_we & hit_tc1;

   always_comb begin
      cpu_rdata = 32'h0;
      if (hit_tc0)
         cpu_rdata = tc0_rdata;
      else if (hit_tc1)
         cpu_rdata = tc1_rdata;
      else if (hit_ic) begin
         case (cpu_addr[1:0])
            IC_IMASK: cpu_rdata = {29'h0, imask};
            IC_IPEND: cpu_rdata = {29'h0, ipend};
            IC_IID:   cpu_rdata = {30'h0, iid};
            default:  cpu_rdata = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1   <= 1'b0;
         sync_ext <= 1'b0;
      end else begin
         sync_1   <= ext_irq;
         sync_ext <= sync_1;
      end
   end

   assign src[SRC_TC0] = tc0_irq;
   assign src[SRC_TC1] = tc1_irq;
   assign src[SRC_EXT] = sync_ext;
   assign active       = ipend & imask;

   // Lowest index wins; IID is index+1 so that 0 means nothing pending.
   always_comb begin
      iid = 2'd0;
      for (int i = NSRC - 1; i >= 0; i--)
         if (active[i])
            iid = 2'(i + 1);
   end

   always_comb begin
      for (int i = 0; i < NSRC; i++)
         clr[i] = (cpu_we && hit_ic && cpu_addr[1:0] == IC_IPEND && cpu_wdata[i])
                | (int_ack && iid == 2'(i + 1));
   end

   for (genvar g = 0; g < NSRC; g++) begin : g_src
      irq_edge_latch u_latch (
         .clk   (clk),
         .reset (reset),
         .src   (src[g]),
         .clr   (clr[g]),
         .pend  (ipend[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         imask  <= '0;
         hw_int <= 6'h0;
      end else begin
         if (cpu_we && hit_ic && cpu_addr[1:0] == IC_IMASK)
            imask <= cpu_wdata[NSRC-1:0];
         hw_int <= {3'b000, active};
      end
   end

`ifdef BRIDGE_TRACE_EN
   always @(posedge clk) begin
      if (cpu_we && cpu_hit)
         $display("@%h: *%h <= %h", cpu_pc, {cpu_addr, 2'b00}, cpu_wdata);
   end
`else
   logic unused_pc;
   assign unused_pc = ^cpu_pc;
`endif

endmodule
